// File: rtl/cfg_chain_loader.sv
// Serial loader for a fabric configuration shift chain: double-buffered words in, one bit per enabled cycle out.
// Define CFG_READBACK_EN to also pack the bits leaving the chain tail into readback words.
module cfg_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 96
) (
  input  logic              config_clk,
  input  logic              config_reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              config_out,
  output logic              config_en,
  input  logic              config_in,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BL_W   = $clog2(CHAIN_LEN + 1);
  localparam int WT_W   = $clog2(NWORDS + 1);
  localparam int CNT_W  = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [BL_W-1:0]   bits_left;
  logic [WT_W-1:0]   words_taken;
  logic [WORD_W-1:0] sh_reg;
  logic [CNT_W-1:0]  sh_cnt;
  logic [WORD_W-1:0] hold_reg;
  logic              hold_full;
  logic              accept;
  logic              last_shift;
  logic              from_hold;

  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    word_ready = 1'b0;
    accept     = 1'b0;
    last_shift = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        busy       = 1'b1;
        word_ready = (words_taken < WT_W'(NWORDS)) && !hold_full;
        accept     = word_valid && word_ready;
        last_shift = config_en && (bits_left == BL_W'(1));
        if (last_shift) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register drains first; the holding word refills it the cycle it runs dry, so words chain with no bubble.
  assign from_hold = (sh_cnt == '0) && hold_full && !last_shift;

  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) begin
      bits_left   <= '0;
      words_taken <= '0;
      sh_reg      <= '0;
      sh_cnt      <= '0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      config_out  <= 1'b0;
      config_en   <= 1'b0;
    end else if (state_q == IDLE) begin
      config_out <= 1'b0;
      config_en  <= 1'b0;
      hold_full  <= 1'b0;
      sh_cnt     <= '0;
      if (start) begin
        bits_left   <= BL_W'(CHAIN_LEN);
        words_taken <= '0;
      end
    end else if (state_q == LOAD) begin
      if (accept)    words_taken <= words_taken + WT_W'(1);
      if (config_en) bits_left   <= bits_left - BL_W'(1);

      if (last_shift) begin
        config_en  <= 1'b0;
        config_out <= 1'b0;
      end else if (sh_cnt != '0) begin
        config_en  <= 1'b1;
        config_out <= sh_reg[0];
        sh_reg     <= sh_reg >> 1;
        sh_cnt     <= sh_cnt - CNT_W'(1);
      end else if (hold_full) begin
        config_en  <= 1'b1;
        config_out <= hold_reg[0];
        sh_reg     <= hold_reg >> 1;
        sh_cnt     <= CNT_W'(WORD_W - 1);
      end else if (accept) begin
        config_en  <= 1'b1;
        config_out <= word_data[0];
        sh_reg     <= word_data >> 1;
        sh_cnt     <= CNT_W'(WORD_W - 1);
      end else begin
        config_en  <= 1'b0;
        config_out <= 1'b0;
      end

      // Upper bits of a partial final word are simply never reached before bits_left hits zero.
      if (accept && (sh_cnt != '0 || hold_full)) begin
        hold_reg  <= word_data;
        hold_full <= 1'b1;
      end else if (from_hold) begin
        hold_full <= 1'b0;
      end
    end else begin
      config_en  <= 1'b0;
      config_out <= 1'b0;
    end
  end

`ifdef CFG_READBACK_EN
  logic [WORD_W-1:0] rb_acc;
  logic [CNT_W-1:0]  rb_cnt;
  logic [WORD_W-1:0] rb_word;

  assign rb_word = rb_acc | (WORD_W'(config_in) << rb_cnt);

  // The tail bit leaving at each enabled edge is the old configuration; a short last word goes out zero-filled.
  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) begin
      rb_acc   <= '0;
      rb_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (state_q == IDLE && start) begin
        rb_acc <= '0;
        rb_cnt <= '0;
      end else if (state_q == LOAD && config_en) begin
        if (rb_cnt == CNT_W'(WORD_W - 1) || last_shift) begin
          rd_data  <= rb_word;
          rd_valid <= 1'b1;
          rb_acc   <= '0;
          rb_cnt   <= '0;
        end else begin
          rb_acc <= rb_word;
          rb_cnt <= rb_cnt + CNT_W'(1);
        end
      end
    end
  end
`else
  logic unused_config_in;
  assign unused_config_in = config_in;
  assign rd_valid = 1'b0;
  assign rd_data  = '0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: a bit-queue model of the stream plus a chain model feeding the tail.
// Readback expectations are compiled in when CFG_READBACK_EN is defined.
module tb_cfg_chain_loader;

  localparam int WORD_W    = 32;
  localparam int CHAIN_LEN = 96;
  localparam int NWORDS    = 3;
  localparam logic [95:0] STREAM_A = 96'hA5A5A5A5_12345678_DEADBEEF;

  logic config_clk = 1'b0;
  always #5 config_clk = ~config_clk;

  logic        config_reset, start, word_valid, config_in;
  logic [31:0] word_data;
  logic        busy, done, word_ready, config_out, config_en, rd_valid;
  logic [31:0] rd_data;

  logic        s40_start, s40_valid;
  logic [31:0] s40_data;
  logic        s40_busy, s40_done, s40_ready, s40_out, s40_en, s40_rd_valid;
  logic [31:0] s40_rd_data;

  cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .config_clk(config_clk), .config_reset(config_reset), .start(start),
    .busy(busy), .done(done), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .config_out(config_out), .config_en(config_en),
    .config_in(config_in), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) dut40 (
    .config_clk(config_clk), .config_reset(config_reset), .start(s40_start),
    .busy(s40_busy), .done(s40_done), .word_valid(s40_valid), .word_data(s40_data),
    .word_ready(s40_ready), .config_out(s40_out), .config_en(s40_en),
    .config_in(1'b0), .rd_valid(s40_rd_valid), .rd_data(s40_rd_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] rev96(input logic [95:0] v);
    logic [95:0] r;
    for (int i = 0; i < 96; i++) r[i] = v[95 - i];
    return r;
  endfunction

  // Chain model: head is bit 0, tail is bit 95, so the first bit shifted in ends up at the tail.
  logic [95:0] chain = '0;
  logic        pre_req;
  logic [95:0] pre_val;
  always @(posedge config_clk) begin
    if (pre_req)        chain <= pre_val;
    else if (config_en) chain <= {chain[94:0], config_out};
  end
  assign config_in = chain[95];

  int          m_phase = 0;
  int          m_words = 0;
  int          m_emitted = 0;
  int          m_gaps = 0;
  int          m_dones = 0;
  bit          exp_q[$];
  logic [95:0] cap = '0;
  logic [31:0] rb_acc = '0;
  int          rb_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_exp = '0;
  logic [31:0] rd_seen[$];
  int          a40 = 0, e40 = 0, d40 = 0, late40 = 0, rd40 = 0;
  logic [39:0] c40 = '0;

  // Model and compare: inputs and outputs are stable at the falling edge, so the next rising edge is predicted here.
  always @(negedge config_clk) begin
    if (config_reset) begin
      m_phase = 0;
      exp_q.delete();
      rb_acc  = '0;
      rb_cnt  = 0;
      rd_pend = 1'b0;
    end else begin
      checkOutput("busy", busy, m_phase == 1);
      checkOutput("done", done, m_phase == 2);
      if (m_phase == 0) checkOutput("idle_outputs", {config_out, config_en, word_ready}, 0);
      if (m_phase != 1 || m_words >= NWORDS) checkOutput("ready_off", word_ready, 0);
      if (m_phase == 2) checkOutput("queue_drained", exp_q.size(), 0);
      if (done) m_dones++;
`ifdef CFG_READBACK_EN
      checkOutput("rd_valid", rd_valid, rd_pend);
      if (rd_valid && rd_pend) begin
        checkOutput("rd_data", rd_data, rd_exp);
        rd_seen.push_back(rd_data);
      end
      rd_pend = 1'b0;
`else
      checkOutput("rd_tied", {rd_valid, rd_data}, 0);
`endif
      if (config_en) begin
        checkOutput("shift_legal", (m_phase == 1) && (exp_q.size() > 0), 1);
        if (m_phase == 1 && exp_q.size() > 0) checkOutput("config_out", config_out, exp_q.pop_front());
        if (m_emitted < 96) cap[m_emitted] = config_out;
        m_emitted++;
`ifdef CFG_READBACK_EN
        rb_acc[rb_cnt] = config_in;
        rb_cnt++;
        if (rb_cnt == WORD_W || m_emitted == CHAIN_LEN) begin
          rd_exp  = rb_acc;
          rd_pend = 1'b1;
          rb_acc  = '0;
          rb_cnt  = 0;
        end
`endif
      end else if (m_phase == 1 && m_emitted > 0 && m_emitted < CHAIN_LEN) begin
        m_gaps++;
      end
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_words = 0; m_emitted = 0; m_gaps = 0; m_dones = 0;
          exp_q.delete(); cap = '0; rb_acc = '0; rb_cnt = 0; rd_seen.delete();
        end
        1: begin
          if (word_valid && word_ready) begin
            for (int i = 0; i < WORD_W; i++)
              if (m_words * WORD_W + i < CHAIN_LEN) exp_q.push_back(word_data[i]);
            m_words++;
          end
          if (config_en && m_emitted == CHAIN_LEN) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end

    if (s40_start && !s40_busy) begin
      a40 = 0; e40 = 0; d40 = 0; late40 = 0; rd40 = 0; c40 = '0;
    end
    if (a40 >= 2 && s40_ready) late40++;
    if (s40_valid && s40_ready) a40++;
    if (s40_en) begin
      if (e40 < 40) c40[e40] = s40_out;
      e40++;
    end
    if (s40_done) d40++;
    if (s40_rd_valid) rd40++;
    checkOutput("rd40_data", s40_rd_data, 0);
  end

  task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                               input int stall, input int restart_at, input int reset_at);
    logic [31:0] ws [3];
    bit ab;
    ab = 1'b0;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    @(posedge config_clk); #1; start = 1'b1;
    @(posedge config_clk); #1; start = 1'b0;
    fork
      begin
        for (int k = 0; k < 3 && !ab; k++) begin
          bit acc;
          if (k == 1 && stall > 0) begin
            for (int t = 0; t < 100; t++) begin
              if (!config_en && m_emitted > 0) break;
              @(posedge config_clk); #1;
            end
            repeat (stall - 1) begin @(posedge config_clk); #1; end
          end
          word_valid = 1'b1;
          word_data  = ws[k];
          acc = 1'b0;
          for (int t = 0; t < 300 && !acc && !ab; t++) begin
            @(negedge config_clk); acc = word_valid && word_ready;
            @(posedge config_clk); #1;
          end
          if (!acc && !ab) checkOutput("word_accept_timeout", 0, 1);
          word_valid = 1'b0;
        end
      end
      begin
        if (restart_at >= 0) begin
          for (int t = 0; t < 300 && m_emitted < restart_at; t++) begin @(posedge config_clk); #1; end
          start = 1'b1;
          @(posedge config_clk); #1; start = 1'b0;
        end
        if (reset_at >= 0) begin
          for (int t = 0; t < 300 && m_emitted < reset_at; t++) begin @(posedge config_clk); #1; end
          config_reset = 1'b1;
          ab = 1'b1;
          #1;
          checkOutput("reset_async", {busy, done, word_ready, config_out, config_en, rd_valid, rd_data}, 0);
          @(posedge config_clk); #1; config_reset = 1'b0;
        end
      end
    join
  endtask

  task automatic checkLoad(input string tag, input int exp_gaps);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(posedge config_clk); #1;
      if (m_dones >= 1 && m_phase == 0) ok = 1'b1;
    end
    repeat (3) begin @(posedge config_clk); #1; end
    checkOutput({tag, "_finished"}, ok, 1);
    checkOutput({tag, "_shifts"}, m_emitted, CHAIN_LEN);
    checkOutput({tag, "_done_pulses"}, m_dones, 1);
    checkOutput({tag, "_stream"}, cap, STREAM_A);
    checkOutput({tag, "_gaps"}, m_gaps, exp_gaps);
    checkOutput({tag, "_chain"}, rev96(chain), STREAM_A);
    checkOutput({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    config_reset = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0;
    s40_start = 1'b0; s40_valid = 1'b0; s40_data = '0;
    pre_req = 1'b0; pre_val = '0;
    #1 config_reset = 1'b1;
    #1;
    checkOutput("reset_state", {busy, done, word_ready, config_out, config_en, rd_valid, rd_data}, 0);
    repeat (3) @(posedge config_clk);
    #1 config_reset = 1'b0;

    $display("[TB] gapless load");
    applyStimulus(32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 0, -1, -1);
    checkLoad("gapless", 0);

    $display("[TB] underrun stall before word 1");
    applyStimulus(32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 5, -1, -1);
    checkLoad("stall", 5);

    $display("[TB] short chain of 40 bits");
    @(posedge config_clk); #1; s40_start = 1'b1;
    @(posedge config_clk); #1; s40_start = 1'b0;
    s40_valid = 1'b1; s40_data = 32'hDEADBEEF;
    for (int t = 0; t < 100 && a40 < 1; t++) begin @(posedge config_clk); #1; end
    s40_data = 32'h12345678;
    for (int t = 0; t < 100 && a40 < 2; t++) begin @(posedge config_clk); #1; end
    s40_data = 32'hA5A5A5A5;
    for (int t = 0; t < 200 && d40 < 1; t++) begin @(posedge config_clk); #1; end
    repeat (3) begin @(posedge config_clk); #1; end
    s40_valid = 1'b0;
    checkOutput("len40_words", a40, 2);
    checkOutput("len40_shifts", e40, 40);
    checkOutput("len40_stream", c40, 40'h78_DEADBEEF);
    checkOutput("len40_done_pulses", d40, 1);
    checkOutput("len40_ready_late", late40, 0);
`ifdef CFG_READBACK_EN
    checkOutput("len40_rd_words", rd40, 2);
`else
    checkOutput("len40_rd_words", rd40, 0);
`endif

    $display("[TB] reset after 50 shifts, then full reload");
    applyStimulus(32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 0, -1, 50);
    repeat (3) begin @(posedge config_clk); #1; end
    checkOutput("post_reset_idle", {busy, done, config_en}, 0);
    applyStimulus(32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 0, -1, -1);
    checkLoad("reload", 0);

    $display("[TB] start pulsed at bit 20");
    applyStimulus(32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 0, 20, -1);
    checkLoad("restart", 0);

`ifdef CFG_READBACK_EN
    $display("[TB] readback of previous configuration");
    @(posedge config_clk); #1;
    pre_val = rev96({32'hFFFFFFFF, 32'h00000000, 32'hCAFEF00D});
    pre_req = 1'b1;
    @(posedge config_clk); #1; pre_req = 1'b0;
    applyStimulus(32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 0, -1, -1);
    checkLoad("readback", 0);
    checkOutput("rb_count", rd_seen.size(), 3);
    if (rd_seen.size() == 3) begin
      checkOutput("rb_word0", rd_seen[0], 32'hCAFEF00D);
      checkOutput("rb_word1", rd_seen[1], 32'h00000000);
      checkOutput("rb_word2", rd_seen[2], 32'hFFFFFFFF);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Serial configuration transmitter that drives the head of a fabric configuration shift chain, such as the chain formed by switch cells and their config_cell registers. It accepts parallel bitstream words from the bitstream DMA/host through a valid/ready handshake. It serialises exactly CHAIN_LEN bits onto the chain and produces a per-cycle shift enable for the chain's clock gate. Optionally, it packs the bits falling out of the chain tail into readback words.

## Interface
- WORD_W, 32, bitstream word width (≥2)
- CHAIN_LEN, 96, total configuration bits in the chain (≥1)
- config_clk  in  1  configuration clock; all state on rising edge
- config_reset  in  1  asynchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE
- busy  out  1  high in LOAD; reset 0
- done  out  1  one-cycle pulse after the final shift; reset 0
- word_valid  in  1  bitstream word offered
- word_data  in  WORD_W  bitstream word; bit 0 is shifted first
- word_ready  out  1  loader accepts word_data this cycle; reset 0
- config_out  out  1  serial bit to the chain head config_in; reset 0
- config_en  out  1  chain shift enable (clock-gate enable); reset 0
- config_in  in  1  chain tail config_out; used only with readback
- rd_valid  out  1  readback word pulse; reset 0 (tied 0 without macro)
- rd_data  out  WORD_W  readback word; reset 0 (tied 0 without macro)

## Operation
- FSM IDLE → LOAD → DONE → IDLE; reset state is IDLE.
- IDLE: all outputs 0. start=1 moves to LOAD and clears the counters: bits_left=CHAIN_LEN and words_taken=0.
- LOAD: NWORDS=ceil(CHAIN_LEN/WORD_W). word_ready = (words_taken<NWORDS) && !hold_full.
- Datapath: a shift register with bit count, plus one holding register (double buffer), so back-to-back words shift without gaps.
- Each cycle with config_en=1 consumes one bit and decrements bits_left. The next bit comes from the shift register, which reloads from the holding register when empty.
- config_en=0 whenever no bit is available (underrun stall). No bit is dropped or duplicated across a stall.
- Last word partial: only the low (CHAIN_LEN mod WORD_W) bits are emitted. The upper bits are discarded.
- When bits_left reaches 0, go to DONE. DONE lasts one cycle with done=1, then returns to IDLE.
- start while busy is ignored. Words offered in IDLE/DONE are not accepted.
- Reset mid-load: everything returns to IDLE and the outputs go to 0 asynchronously. The chain is left partially loaded and is restored by a new full load.

## Timing
- start at edge E0: busy=1 after E0. word_ready can be high in the cycle after E0.
- A word accepted at edge E1 (valid&&ready): config_out=bit0 and config_en=1 after E1. The chain captures bit0 at E2.
- The chain samples config_out on every rising edge at which config_en=1. config_out and config_en are registered, with no combinational path from inputs.
- Words supplied with no gaps give CHAIN_LEN consecutive config_en cycles.
- The final shift happens at edge Ef. After Ef: config_en=0, done=1 and busy=0 (DONE). The loader is back in IDLE after Ef+1.
- Simultaneous word accept and hold→shift transfer in the same cycle is legal and required for gapless operation.

## Configuration
- CFG_READBACK_EN defined:
  - config_in is sampled at each edge with config_en=1. This is the tail bit being shifted out, i.e. the previous configuration.
  - Sampled bits are packed LSB-first into rd_data.
  - rd_valid pulses for one cycle when WORD_W bits are collected. At the end of a load it also pulses once for a final partial word, zero-filled.
  - There is no backpressure on rd_valid.
  - Exactly NWORDS readback words are produced per load.
- CFG_READBACK_EN undefined: config_in is ignored and rd_valid/rd_data are constant 0. No readback registers are built.

## Test plan
- CHAIN_LEN=96, WORD_W=32, words 0xDEADBEEF, 0x12345678, 0xA5A5A5A5 held valid → config_en high for exactly 96 consecutive cycles. Captured bits equal the words LSB-first. One done pulse, then busy=0.
- Same load with word_valid dropped for 5 cycles before word 1 → exactly 5 config_en=0 cycles mid-stream. Captured 96-bit stream is identical.
- CHAIN_LEN=40 → exactly 2 words accepted and word_ready stays 0 afterwards. 40 shifts occur, and bits [31:8] of word 1 are never emitted.
- Assert config_reset after 50 shifts → all outputs 0 immediately, state IDLE. A fresh start then loads all 96 bits correctly.
- start pulsed again at bit 20 of a load → ignored: still 96 shifts and a single done pulse.
- CFG_READBACK_EN, chain model preloaded with 0xCAFEF00D/0x0/0xFFFFFFFF → three rd_valid pulses with exactly those values. The new words are resident in the chain afterwards.
